// File: rtl/i2s_mem_ctrl.sv
// I2S sample buffer controller: two ping-pong sample RAMs delivered to an I2S writer over a four-phase handshake.
// Build option I2S_MEM_CTRL_REPEAT_EN: on underrun re-serve the last delivered sample instead of zero.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | stopped; lr phase re-armed on exit
// WAIT_REQ | armed, waiting for synced request (or enable drop)
// FETCH    | RAM read issued, pointer / buffer bookkeeping
// ACK      | sample latched onto audio_data, ack raised
// RELEASE  | ack held until synced request falls
module i2s_mem_ctrl #(
   parameter int BUF_AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr_stb,
   input  logic              wr_buf,
   input  logic [BUF_AW-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   input  logic              commit_stb,
   input  logic              commit_buf,
   input  logic [BUF_AW:0]   commit_count,
   input  logic              underrun_clr,
   input  logic              audio_data_request,
   output logic              audio_data_ack,
   output logic [23:0]       audio_data,
   output logic              audio_lr_bit,
   output logic [1:0]        buf_ready,
   output logic [1:0]        buf_done,
   output logic              active_buf,
   output logic              underrun
);

   localparam int              DEPTH   = 1 << BUF_AW;
   localparam logic [BUF_AW:0] MAX_CNT = DEPTH[BUF_AW:0];

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_REQ = 3'd1,
      FETCH    = 3'd2,
      ACK      = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   state_t state_q;
   state_t state_d;

   logic              req_meta;
   logic              req_sync;
   logic [23:0]       mem [2*DEPTH];
   logic [23:0]       rd_q;
   logic [BUF_AW-1:0] rd_ptr;
   logic [BUF_AW:0]   ptr_inc;
   logic [BUF_AW:0]   cnt_q [2];
   logic              urf_q;
   logic              lr_q;
   logic [23:0]       fill_data;
   logic              wr_en;
   logic              commit_ok;
   logic              fetch_go;
   logic              ack_go;
   logic              rel_done;
   logic              idle_exit;
   logic              starve;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_meta <= 1'b0;
         req_sync <= 1'b0;
      end else begin
         req_meta <= audio_data_request;
         req_sync <= req_meta;
      end
   end

   assign wr_en     = wr_stb && !buf_ready[wr_buf];
   assign commit_ok = commit_stb && !buf_ready[commit_buf] &&
                      (commit_count != '0) && (commit_count <= MAX_CNT);

   // RAM has no reset; contents are don't-care until rewritten by the host
   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_buf, wr_addr}] <= wr_data;
      if (fetch_go) rd_q <= mem[{active_buf, rd_ptr}];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (enable) state_d = WAIT_REQ;
         WAIT_REQ: begin
            if (!enable)       state_d = IDLE;
            else if (req_sync) state_d = FETCH;
         end
         FETCH:    state_d = ACK;
         ACK:      state_d = RELEASE;
         RELEASE:  if (!req_sync) state_d = enable ? WAIT_REQ : IDLE;
         default:  state_d = IDLE;
      endcase
   end

   assign fetch_go  = (state_q == FETCH);
   assign ack_go    = (state_q == ACK);
   assign rel_done  = (state_q == RELEASE) && !req_sync;
   assign idle_exit = (state_q == IDLE) && enable;
   assign starve    = fetch_go && !buf_ready[active_buf];
   assign ptr_inc   = {1'b0, rd_ptr} + {{BUF_AW{1'b0}}, 1'b1};

`ifdef I2S_MEM_CTRL_REPEAT_EN
   assign fill_data = audio_data;
`else
   assign fill_data = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_ready      <= '0;
         buf_done       <= '0;
         active_buf     <= 1'b0;
         rd_ptr         <= '0;
         cnt_q[0]       <= '0;
         cnt_q[1]       <= '0;
         urf_q          <= 1'b0;
         lr_q           <= 1'b0;
         audio_data     <= '0;
         audio_lr_bit   <= 1'b0;
         audio_data_ack <= 1'b0;
      end else begin
         buf_done <= '0;
         // a commit only lands on a non-ready buffer, a consume only on a ready one: never the same bit
         if (commit_ok) begin
            cnt_q[commit_buf]     <= commit_count;
            buf_ready[commit_buf] <= 1'b1;
         end
         if (fetch_go) begin
            urf_q <= !buf_ready[active_buf];
            if (buf_ready[active_buf]) begin
               if (ptr_inc == cnt_q[active_buf]) begin
                  buf_ready[active_buf] <= 1'b0;
                  buf_done[active_buf]  <= 1'b1;
                  rd_ptr                <= '0;
                  active_buf            <= ~active_buf;
               end else begin
                  rd_ptr <= ptr_inc[BUF_AW-1:0];
               end
            end
         end
         if (idle_exit) lr_q <= 1'b0;
         if (ack_go) begin
            audio_data     <= urf_q ? fill_data : rd_q;
            audio_lr_bit   <= lr_q;
            lr_q           <= ~lr_q;
            audio_data_ack <= 1'b1;
         end
         if (rel_done) audio_data_ack <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              underrun <= 1'b0;
      else if (starve)       underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
   end

endmodule
